// File: rtl/tf_pkg.sv
// tf_pkg: shared defaults, FIFO sizing and FSM encoding for the twiddle fetch block.
package tf_pkg;
  localparam int TF_ADDR_W     = 6;
  localparam int TF_DATA_W     = 36;
  localparam int TF_NUM_TF     = 43;
  localparam int TF_FIFO_DEPTH = 4;
  localparam int TF_CNT_W      = $clog2(TF_FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } tf_state_e;
endpackage

// File: rtl/tf_fifo.sv
// tf_fifo: synchronous 4-deep FIFO with full/empty/count. Head entry is read
// straight from storage flops. The caller must not write when full unless it
// reads in the same cycle.
module tf_fifo
  import tf_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_wr,
  input  logic [W-1:0]        i_wdata,
  input  logic                i_rd,
  output logic [W-1:0]        o_rdata,
  output logic                o_full,
  output logic                o_empty,
  output logic [TF_CNT_W-1:0] o_count
);
  localparam int PTR_W = $clog2(TF_FIFO_DEPTH);
  localparam logic [TF_CNT_W-1:0] LP_FULL = TF_CNT_W'(TF_FIFO_DEPTH);

  logic [W-1:0]        r_mem [TF_FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [TF_CNT_W-1:0] r_count;
  logic                w_do_rd;

  assign w_do_rd = i_rd && (r_count != '0);
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == LP_FULL);
  assign o_count = r_count;

  // storage write, no reset needed: entries are only visible when counted
  always_ff @(posedge clk) begin
    if (i_wr) r_mem[r_wr_ptr] <= i_wdata;
  end

  // pointers and occupancy; simultaneous write and read leaves count unchanged
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_wr)    r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_wr, w_do_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/tf_fetch.sv
// tf_fetch: streams one pass of twiddle words (ROM addresses 0..NUM_TF-1) from
// a ROM with one-cycle registered read to the butterfly datapath via tf_fifo.
// Optional feature: define TF_FETCH_IDX_EN to add output tf_idx, the ROM
// address of the word on tf_data.
//
//   state    | meaning
//   ST_IDLE  | waiting for start (a start in the done cycle is ignored)
//   ST_RUN   | issuing ROM reads whenever the FIFO has room for them
//   ST_DRAIN | last read issued, waiting for the last word to be taken
module tf_fetch
  import tf_pkg::*;
#(
  parameter int ADDR_W = TF_ADDR_W,
  parameter int DATA_W = TF_DATA_W,
  parameter int NUM_TF = TF_NUM_TF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_a,
  output logic              rom_en,
  input  logic [DATA_W-1:0] rom_q,
  output logic [DATA_W-1:0] tf_data,
  output logic              tf_valid,
  input  logic              tf_ready,
  output logic              tf_last
`ifdef TF_FETCH_IDX_EN
  ,
  output logic [ADDR_W-1:0] tf_idx
`endif
);
`ifdef TF_FETCH_IDX_EN
  localparam int ENT_W = DATA_W + 1 + ADDR_W;
`else
  localparam int ENT_W = DATA_W + 1;
`endif
  localparam logic [ADDR_W-1:0] LP_LAST_A = ADDR_W'(NUM_TF - 1);
  localparam logic [ADDR_W:0]   LP_NUM    = (ADDR_W+1)'(NUM_TF);

  tf_state_e           r_state;
  logic [ADDR_W:0]     r_addr;
  logic [ADDR_W-1:0]   r_rom_a;
  logic                r_rom_en;
  logic                r_busy;
  logic                r_done;
  logic                r_q_vld;
  logic                r_q_last;
`ifdef TF_FETCH_IDX_EN
  logic [ADDR_W-1:0]   r_q_idx;
`endif
  logic [ENT_W-1:0]    w_wdata;
  logic [ENT_W-1:0]    w_rdata;
  logic                w_wr;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [TF_CNT_W-1:0] w_count;
  logic [3:0]          w_proj;
  logic                w_room;

  assign w_pop = !w_empty && tf_ready;
  assign w_wr  = r_q_vld && (!w_full || w_pop);
  // next cycle's occupancy plus the read that will then still be in flight
  assign w_proj = 4'(w_count) + 4'(r_q_vld) + 4'(r_rom_en) - 4'(w_pop);
  assign w_room = (w_proj < 4'(TF_FIFO_DEPTH));

`ifdef TF_FETCH_IDX_EN
  assign w_wdata = {r_q_idx, rom_q, r_q_last};
  assign tf_idx  = w_empty ? '0 : w_rdata[ENT_W-1 -: ADDR_W];
`else
  assign w_wdata = {rom_q, r_q_last};
`endif

  tf_fifo #(.W(ENT_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wr    (w_wr),
    .i_wdata (w_wdata),
    .i_rd    (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // outputs forced to zero whenever the FIFO head is not valid
  assign tf_valid = !w_empty;
  assign tf_data  = w_empty ? '0 : w_rdata[DATA_W:1];
  assign tf_last  = !w_empty && w_rdata[0];
  assign busy     = r_busy;
  assign done     = r_done;
  assign rom_a    = r_rom_a;
  assign rom_en   = r_rom_en;

  // ROM response tracking: data is on rom_q exactly one cycle after rom_en
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q_vld  <= 1'b0;
      r_q_last <= 1'b0;
`ifdef TF_FETCH_IDX_EN
      r_q_idx  <= '0;
`endif
    end else begin
      r_q_vld  <= r_rom_en;
      r_q_last <= r_rom_en && (r_rom_a == LP_LAST_A);
`ifdef TF_FETCH_IDX_EN
      r_q_idx  <= r_rom_a;
`endif
    end
  end

  // pass sequencing FSM with registered busy/done/rom_en/rom_a
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_rom_a  <= '0;
      r_rom_en <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_rom_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && !r_done) begin
            r_state  <= ST_RUN;
            r_busy   <= 1'b1;
            r_rom_en <= 1'b1;
            r_rom_a  <= '0;
            r_addr   <= (ADDR_W+1)'(1);
          end
        end
        ST_RUN: begin
          if (r_rom_en && (r_rom_a == LP_LAST_A)) begin
            r_state <= ST_DRAIN;
          end else if (w_room && (r_addr < LP_NUM)) begin
            r_rom_en <= 1'b1;
            r_rom_a  <= r_addr[ADDR_W-1:0];
            r_addr   <= r_addr + (ADDR_W+1)'(1);
          end
        end
        ST_DRAIN: begin
          if (w_pop && w_rdata[0]) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tf_fetch.sv
// tb_tf_fetch: directed bench for tf_fetch with a stream-level reference model.
// Define TF_FETCH_IDX_EN to also check tf_idx.
module tb_tf_fetch;
  localparam int NUM = 43;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic [5:0]  rom_a;
  logic        rom_en;
  logic [35:0] rom_q = '0;
  logic [35:0] tf_data;
  logic        tf_valid;
  logic        tf_ready;
  logic        tf_last;
`ifdef TF_FETCH_IDX_EN
  logic [5:0]  tf_idx;
`endif

  tf_fetch dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .rom_a    (rom_a),
    .rom_en   (rom_en),
    .rom_q    (rom_q),
    .tf_data  (tf_data),
    .tf_valid (tf_valid),
    .tf_ready (tf_ready),
    .tf_last  (tf_last)
`ifdef TF_FETCH_IDX_EN
    ,
    .tf_idx   (tf_idx)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [35:0] rom_word(input int a);
    logic [35:0] w;
    w = 36'(a) * 36'h0_9E37_79B1 + 36'h5_A5A5_A5A5;
    return w;
  endfunction

  // ROM with registered read
  always @(posedge clk) if (rom_en) rom_q <= rom_word(int'(rom_a));

  int total = 0;
  int bad   = 0;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // reference model state: what the stream must look like this cycle
  bit          rst_prev = 1'b0;
  bit          e_busy = 1'b0;
  bit          e_done = 1'b0;
  int          m_issue = 0;
  int          m_pop = 0;
  bit          stall_prev = 1'b0;
  logic [35:0] sd = '0;
  bit          sl = 1'b0;
  logic [5:0]  prev_rom_a = '0;
  int          n_done = 0;
  int          n_last = 0;
  int          first_en_cyc = -1;
  int          last_en_cyc = -1;
  int          first_valid_cyc = -1;
  int          last_hs_cyc = -1;
  int          done_cyc = -1;

  always @(negedge clk) begin
    bit hs;
    if (!rst_prev) begin
      chk({busy, done, rom_en, tf_valid, tf_last} == 5'b0 && rom_a == '0,
          "reset_ctrl", 64'({busy, done, rom_en, tf_valid, tf_last, rom_a}), 0);
      chk(tf_data == '0, "reset_data", 64'(tf_data), 0);
`ifdef TF_FETCH_IDX_EN
      chk(tf_idx == '0, "reset_idx", 64'(tf_idx), 0);
`endif
      e_busy = 0; e_done = 0; m_issue = 0; m_pop = 0; stall_prev = 0;
    end else begin
      chk(busy == e_busy, "busy", 64'(busy), 64'(e_busy));
      chk(done == e_done, "done", 64'(done), 64'(e_done));
      if (rom_en) begin
        chk(e_busy && int'(rom_a) == m_issue && m_issue < NUM && (m_issue - m_pop) < 4,
            "rom_read", 64'(rom_a), 64'(m_issue));
        if (m_issue == 0) first_en_cyc = cyc;
        if (m_issue == NUM - 1) last_en_cyc = cyc;
        m_issue++;
      end else begin
        chk(rom_a == prev_rom_a, "rom_a_hold", 64'(rom_a), 64'(prev_rom_a));
      end
      if (stall_prev)
        chk(tf_valid && tf_data == sd && tf_last == sl, "stall_hold", 64'(tf_data), 64'(sd));
      if (tf_valid) begin
        chk(e_busy && m_pop < NUM && tf_data == rom_word(m_pop), "word_data",
            64'(tf_data), 64'(rom_word(m_pop)));
        chk(tf_last == (m_pop == NUM - 1), "word_last", 64'(tf_last), 64'(m_pop == NUM - 1));
`ifdef TF_FETCH_IDX_EN
        chk(int'(tf_idx) == m_pop, "word_idx", 64'(tf_idx), 64'(m_pop));
`endif
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      hs = tf_valid && tf_ready;
      stall_prev = tf_valid && !tf_ready;
      sd = tf_data;
      sl = tf_last;
      if (hs) begin
        if (tf_last) begin
          n_last++;
          last_hs_cyc = cyc;
        end
        m_pop++;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (hs && m_pop == NUM) begin
        e_done = 1; e_busy = 0;
      end else if (start && !e_busy && !e_done) begin
        e_busy = 1; e_done = 0; m_issue = 0; m_pop = 0;
        first_en_cyc = -1; last_en_cyc = -1; first_valid_cyc = -1;
        last_hs_cyc = -1; done_cyc = -1;
      end else begin
        e_done = 0;
      end
    end
    prev_rom_a = rom_a;
    rst_prev = rst_n;
  end

  task automatic goto_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    int c;
    c = cyc;
    start = 1'b1;
    goto_cyc(c + 1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm, input bit rnd);
    int d0;
    int k;
    d0 = n_done;
    k = 0;
    while (n_done == d0 && k < budget) begin
      if (rnd) tf_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      k++;
    end
    chk(n_done != d0, nm, 64'(n_done - d0), 1);
    tf_ready = 1'b1;
  endtask

  initial begin
    int s;
    int d0;
    int l0;
    int k;
    rst_n = 1'b0; start = 1'b0; tf_ready = 1'b1;
    goto_cyc(3);
    rst_n = 1'b1;

    // nominal pass, start in cycle 10
    goto_cyc(10);
    pulse_start();
    wait_done(120, "t1_done_seen", 0);
    chk(first_en_cyc == 11, "t1_first_read_cyc", 64'(first_en_cyc), 11);
    chk(last_en_cyc == 53, "t1_last_read_cyc", 64'(last_en_cyc), 53);
    chk(first_valid_cyc == 13, "t1_first_valid_cyc", 64'(first_valid_cyc), 13);
    chk(last_hs_cyc == 55, "t1_last_cyc", 64'(last_hs_cyc), 55);
    chk(done_cyc == 56, "t1_done_cyc", 64'(done_cyc), 56);
    chk(m_pop == NUM, "t1_words", 64'(m_pop), NUM);

    // consumer stalled 20 cycles after start
    goto_cyc(cyc + 3);
    tf_ready = 1'b0;
    s = cyc;
    pulse_start();
    goto_cyc(s + 20);
    chk(m_issue >= 1 && m_issue <= 4, "t2_reads_issued", 64'(m_issue), 4);
    chk(m_pop == 0, "t2_none_taken", 64'(m_pop), 0);
    chk(tf_valid && tf_data == rom_word(0), "t2_head_word", 64'(tf_data), 64'(rom_word(0)));
    tf_ready = 1'b1;
    wait_done(120, "t2_done_seen", 0);
    chk(m_pop == NUM, "t2_words", 64'(m_pop), NUM);

    // random consumer
    goto_cyc(cyc + 3);
    d0 = n_done; l0 = n_last;
    pulse_start();
    wait_done(600, "t3_done_seen", 1);
    goto_cyc(cyc + 5);
    chk(m_pop == NUM, "t3_words", 64'(m_pop), NUM);
    chk(n_last - l0 == 1, "t3_last_count", 64'(n_last - l0), 1);
    chk(n_done - d0 == 1, "t3_done_count", 64'(n_done - d0), 1);

    // reset mid-pass at word 20, then a fresh pass
    goto_cyc(cyc + 3);
    d0 = n_done;
    pulse_start();
    k = 0;
    while (m_pop < 20 && k < 100) begin
      goto_cyc(cyc + 1);
      k++;
    end
    chk(m_pop == 20, "t4_reach_word20", 64'(m_pop), 20);
    rst_n = 1'b0;
    goto_cyc(cyc + 1);
    chk({busy, done, rom_en, tf_valid, tf_last} == 5'b0 && rom_a == '0 && tf_data == '0,
        "t4_reset_zero", 64'({busy, done, rom_en, tf_valid, tf_last, rom_a}), 0);
    rst_n = 1'b1;
    goto_cyc(cyc + 3);
    chk(!busy && !tf_valid && !rom_en, "t4_quiet", 64'({busy, tf_valid, rom_en}), 0);
    chk(n_done == d0, "t4_no_done", 64'(n_done - d0), 0);
    s = cyc;
    pulse_start();
    wait_done(120, "t4_done_seen", 0);
    chk(first_valid_cyc == s + 3, "t4_first_valid", 64'(first_valid_cyc), 64'(s + 3));
    chk(m_pop == NUM, "t4_words", 64'(m_pop), NUM);

    // start while busy and in the done cycle is ignored
    goto_cyc(cyc + 3);
    d0 = n_done;
    s = cyc;
    pulse_start();
    goto_cyc(s + 20);
    pulse_start();
    goto_cyc(s + 46);
    pulse_start();
    goto_cyc(s + 80);
    chk(done_cyc == s + 46, "t5_done_cyc", 64'(done_cyc), 64'(s + 46));
    chk(n_done - d0 == 1, "t5_single_done", 64'(n_done - d0), 1);
    chk(first_en_cyc == s + 1, "t5_no_restart", 64'(first_en_cyc), 64'(s + 1));
    chk(!busy && !rom_en, "t5_idle", 64'({busy, rom_en}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/tf_fetch.md
TF_FETCH -- requirements
Module: tf_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, twiddle ROM address width.
REQ-002 SHALL have parameter DATA_W, default 36, twiddle word width.
REQ-003 SHALL have parameter NUM_TF, default 43, twiddle words per pass (addresses 0..NUM_TF-1).
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  input  1  pulse that begins one fetch pass.
REQ-007 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-008 SHALL have port done  output  1  one-cycle pulse when the pass completes.
REQ-009 SHALL have port rom_a  output  ADDR_W  ROM read address.
REQ-010 SHALL have port rom_en  output  1  ROM read enable; ROM returns data one cycle later.
REQ-011 SHALL have port rom_q  input  DATA_W  ROM registered read data.
REQ-012 SHALL have port tf_data  output  DATA_W  twiddle word to butterfly datapath.
REQ-013 SHALL have port tf_valid  output  1  tf_data valid.
REQ-014 SHALL have port tf_ready  input  1  consumer accepts word.
REQ-015 SHALL have port tf_last  output  1  high with the word from address NUM_TF-1.

Function
REQ-016 SHALL implement FSM IDLE -> RUN (start in IDLE) -> DRAIN (last read issued) -> IDLE (last word handshaken, done pulsed).
REQ-017 SHALL ignore start outside IDLE.
REQ-018 SHALL issue reads at addresses 0,1,...,NUM_TF-1 in order, rom_en high only in RUN; rom_a held when rom_en low.
REQ-019 SHALL capture rom_q exactly one cycle after each rom_en into a 4-entry FIFO.
REQ-020 SHALL assert rom_en only when FIFO occupancy plus reads in flight < 4; FIFO never overflows.
REQ-021 SHALL drive tf_valid/tf_data/tf_last from a registered FIFO head; handshake = tf_valid & tf_ready.
REQ-022 SHALL hold tf_data, tf_last, tf_valid stable while tf_valid & !tf_ready.
REQ-023 SHALL, with tf_ready held high, assert first tf_valid 3 cycles after the start cycle and sustain 1 word/cycle.
REQ-024 SHALL pulse done the cycle after the tf_last handshake; busy falls in the same cycle as done.
REQ-025 SHALL deliver words with no loss, duplication or reordering under arbitrary tf_ready patterns.
REQ-026 SHALL handle simultaneous FIFO write and read without occupancy error (including at full and empty).
REQ-027 SHALL support back-to-back passes: start accepted in the cycle done is high is ignored (FSM already IDLE next cycle only).

Reset
REQ-028 SHALL, on rst_n low at a clock edge, set FSM IDLE, address counter 0, FIFO empty, in-flight count 0.
REQ-029 SHALL drive busy=0, done=0, rom_en=0, rom_a=0, tf_valid=0, tf_last=0, tf_data=0 during and after reset.
REQ-030 SHALL, on reset mid-pass, discard all buffered and in-flight words; the ROM response in the following cycle is dropped.

Configuration
REQ-031 SHALL, with macro TF_FETCH_IDX_EN defined, add output port tf_idx (ADDR_W) carrying the ROM address of the word on tf_data, reset 0, stable under stall.
REQ-032 SHALL, without TF_FETCH_IDX_EN, omit tf_idx port and its FIFO storage.

Structure
REQ-033 SHALL place default ADDR_W, DATA_W, NUM_TF, FIFO depth 4 and FSM state enum in shared package tf_pkg.
REQ-034 SHALL implement the FIFO as sub-module tf_fifo (synchronous, depth 4, full/empty/count).

Verification
REQ-035 SHALL test: reset, start at cycle 10, tf_ready=1 -> rom_a 0..42 on cycles 11..53, tf_valid cycles 13..55, tf_last cycle 55, done cycle 56.
REQ-036 SHALL test: tf_ready=0 for 20 cycles after start -> at most 4 reads issued, tf_data holds word from address 0, then resumes in order.
REQ-037 SHALL test: tf_ready random 50% -> 43 words equal ROM contents for addresses 0..42 in order, exactly one tf_last, one done.
REQ-038 SHALL test: rst_n low 1 cycle at word 20 -> all outputs 0 next cycle, new start yields full 43-word pass from address 0.
REQ-039 SHALL test: start pulsed while busy and in done cycle -> ignored, no second pass.
REQ-040 SHALL test: with TF_FETCH_IDX_EN, tf_idx equals 0..42 matching each handshaken word.
